// File: rtl/color_memory.sv
// color_memory: 8-entry palette of 24-bit {G,B,R} LED colors.
// Combinational read, clocked byte-enabled write, synchronous defaults restore,
// and asynchronous reset back to the default palette.
module color_memory #(
    parameter int unsigned ADDR_W = 3,
    parameter int unsigned DATA_W = 24
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_W-1:0]     addr,
    output logic [DATA_W-1:0]     data_out,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic [DATA_W/8-1:0]   wr_be,
    input  logic                  restore
);

    localparam int unsigned DEPTH  = 1 << ADDR_W;
    localparam int unsigned NBYTES = DATA_W / 8;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];

    // Default palette: white, red, off, green, teal, then off for the rest.
    function automatic logic [DATA_W-1:0] default_color(input int unsigned idx);
        logic [DATA_W-1:0] color;
        case (idx)
            0:       color = DATA_W'(24'hFFFFFF);
            1:       color = DATA_W'(24'h0000FF);
            3:       color = DATA_W'(24'hFF0000);
            4:       color = DATA_W'(24'hFFFF00);
            default: color = '0;
        endcase
        return color;
    endfunction

    // Next palette contents: restore wins over a same-cycle write.
    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (restore) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_d[i] = default_color(i);
            end
        end else if (wr_en) begin
            for (int unsigned k = 0; k < NBYTES; k++) begin
                if (wr_be[k]) begin
                    mem_d[wr_addr][8*k +: 8] = wr_data[8*k +: 8];
                end
            end
        end
    end

    // Palette storage; reset reloads defaults without waiting for a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= default_color(i);
            end
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    // Zero-latency read so serializers see the color as soon as the code changes.
    always_comb begin
        data_out = mem_q[addr];
    end

endmodule

// File: tb/tb_color_memory.sv
// Self-checking bench for color_memory against an array-based palette model.
module tb_color_memory;

    logic        clk;
    logic        rst_n;
    logic [2:0]  addr;
    logic [23:0] data_out;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [23:0] wr_data;
    logic [2:0]  wr_be;
    logic        restore;

    int vectors;
    int errors;

    logic [23:0] defaults [8] = '{24'hFFFFFF, 24'h0000FF, 24'h000000, 24'hFF0000,
                                  24'hFFFF00, 24'h000000, 24'h000000, 24'h000000};
    logic [23:0] model [8];

    color_memory dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .addr     (addr),
        .data_out (data_out),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_be    (wr_be),
        .restore  (restore)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one write/restore cycle at the next rising edge and update the model.
    task automatic drive_cycle(input logic we, input logic [2:0] wa, input logic [23:0] wd,
                               input logic [2:0] be, input logic rs);
        logic [23:0] mask;
        @(negedge clk);
        wr_en = we; wr_addr = wa; wr_data = wd; wr_be = be; restore = rs;
        @(posedge clk);
        if (rs) begin
            for (int i = 0; i < 8; i++) model[i] = defaults[i];
        end else if (we) begin
            mask = {{8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
            model[wa] = (model[wa] & ~mask) | (wd & mask);
        end
        #1;
        wr_en = 1'b0; restore = 1'b0; wr_be = 3'b000;
    endtask

    task automatic test_reset();
        addr = 3'd0;
        #10;
        vectors++;
        if (data_out !== 24'hFFFFFF) begin
            errors++;
            $display("FAIL reset_during addr=0 got %06h want FFFFFF", data_out);
        end
        #10;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) model[i] = defaults[i];
        for (int a = 0; a < 8; a++) begin
            addr = 3'(a);
            #1;
            vectors++;
            if (data_out !== model[a]) begin
                errors++;
                $display("FAIL reset_sweep addr=%0d got %06h want %06h", a, data_out, model[a]);
            end
            #9;
        end
    endtask

    task automatic test_full_write();
        drive_cycle(1'b1, 3'd6, 24'h12AB34, 3'b111, 1'b0);
        addr = 3'd6;
        #1;
        vectors++;
        if (data_out !== 24'h12AB34) begin
            errors++;
            $display("FAIL full_write addr=6 got %06h want 12AB34", data_out);
        end
    endtask

    task automatic test_byte_enable();
        drive_cycle(1'b1, 3'd1, 24'h550000, 3'b100, 1'b0);
        addr = 3'd1;
        #1;
        vectors++;
        if (data_out !== 24'h5500FF) begin
            errors++;
            $display("FAIL byte_enable addr=1 got %06h want 5500FF", data_out);
        end
    endtask

    task automatic test_be_zero();
        drive_cycle(1'b1, 3'd4, 24'h010203, 3'b000, 1'b0);
        addr = 3'd4;
        #1;
        vectors++;
        if (data_out !== 24'hFFFF00) begin
            errors++;
            $display("FAIL be_zero addr=4 got %06h want FFFF00", data_out);
        end
    endtask

    task automatic test_restore_priority();
        drive_cycle(1'b1, 3'd3, 24'h000000, 3'b111, 1'b1);
        addr = 3'd3;
        #1;
        vectors++;
        if (data_out !== 24'hFF0000) begin
            errors++;
            $display("FAIL restore_prio addr=3 got %06h want FF0000", data_out);
        end
        addr = 3'd6;
        #1;
        vectors++;
        if (data_out !== 24'h000000) begin
            errors++;
            $display("FAIL restore_entry6 addr=6 got %06h want 000000", data_out);
        end
        addr = 3'd1;
        #1;
        vectors++;
        if (data_out !== 24'h0000FF) begin
            errors++;
            $display("FAIL restore_entry1 addr=1 got %06h want 0000FF", data_out);
        end
    endtask

    task automatic test_async_reset();
        drive_cycle(1'b1, 3'd0, 24'h123456, 3'b111, 1'b0);
        addr = 3'd0;
        #1;
        vectors++;
        if (data_out !== 24'h123456) begin
            errors++;
            $display("FAIL async_pre addr=0 got %06h want 123456", data_out);
        end
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (data_out !== 24'hFFFFFF) begin
            errors++;
            $display("FAIL async_reset addr=0 got %06h want FFFFFF", data_out);
        end
        wr_en = 1'b1; wr_addr = 3'd2; wr_data = 24'hAAAAAA; wr_be = 3'b111;
        repeat (2) @(posedge clk);
        #1;
        addr = 3'd2;
        #1;
        vectors++;
        if (data_out !== 24'h000000) begin
            errors++;
            $display("FAIL write_in_reset addr=2 got %06h want 000000", data_out);
        end
        for (int i = 0; i < 8; i++) model[i] = defaults[i];
        @(negedge clk);
        wr_en = 1'b0; wr_be = 3'b000;
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        logic [2:0]  ra;
        logic [23:0] old_val;
        logic [23:0] mask;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            wr_en   = ($urandom_range(0, 3) != 0);
            wr_addr = 3'($urandom_range(0, 7));
            wr_data = 24'($urandom);
            wr_be   = 3'($urandom_range(0, 7));
            restore = ($urandom_range(0, 15) == 0);
            ra      = ($urandom_range(0, 1) == 0) ? wr_addr : 3'($urandom_range(0, 7));
            addr    = ra;
            #1;
            old_val = model[ra];
            vectors++;
            if (data_out !== old_val) begin
                errors++;
                $display("FAIL rand_pre n=%0d addr=%0d got %06h want %06h", n, ra, data_out, old_val);
            end
            @(posedge clk);
            if (restore) begin
                for (int i = 0; i < 8; i++) model[i] = defaults[i];
            end else if (wr_en) begin
                mask = {{8{wr_be[2]}}, {8{wr_be[1]}}, {8{wr_be[0]}}};
                model[wr_addr] = (model[wr_addr] & ~mask) | (wr_data & mask);
            end
            #1;
            vectors++;
            if (data_out !== model[ra]) begin
                errors++;
                $display("FAIL rand_post n=%0d addr=%0d got %06h want %06h", n, ra, data_out, model[ra]);
            end
        end
        wr_en = 1'b0; restore = 1'b0; wr_be = 3'b000;
        for (int a = 0; a < 8; a++) begin
            addr = 3'(a);
            #1;
            vectors++;
            if (data_out !== model[a]) begin
                errors++;
                $display("FAIL rand_final addr=%0d got %06h want %06h", a, data_out, model[a]);
            end
        end
    endtask

    initial begin
        vectors = 0;
        errors  = 0;
        rst_n   = 1'b0;
        addr    = 3'd0;
        wr_en   = 1'b0;
        wr_addr = 3'd0;
        wr_data = 24'h0;
        wr_be   = 3'b000;
        restore = 1'b0;
        test_reset();
        test_full_write();
        test_byte_enable();
        test_be_zero();
        test_restore_priority();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
